ram_scan_reader: RTL and testbench

- Read-side companion to the 16x4 result RAM. The write side stores F1 in bit 0, the 2-bit adder sum in bits 2:1, and the adder carry in bit 3.
- On START, sweeps the RAM address range and decodes each stored word. Presents each word to a downstream consumer over a VALID/READY handshake.
- Accumulates scan statistics: F1 hit count, adder-result total, and maximum result with its address.
- Drives the RAM address bus only while BUSY. The top-level mux gives the address to the writer otherwise.

---
 rtl/ram_scan_pkg.sv | 23 ++
 rtl/ram_word_decode.sv | 13 +
 rtl/ram_scan_reader.sv | 133 +++++++++++++
 tb/tb_ram_scan_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_scan_pkg.sv
// Shared types and field layout for the 16x4 result RAM word format.
package ram_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD,
        ST_DONE
    } scan_state_t;

    // Stored word: bit 3 = adder carry, bits 2:1 = adder sum, bit 0 = F1.
    localparam int WORD_W   = 4;
    localparam int F1_POS   = 0;
    localparam int SUM_LSB  = 1;
    localparam int SUM_MSB  = 2;
    localparam int COUT_POS = 3;

    localparam int ADD_W = 3;
    localparam int CNT_W = 5;
    localparam int TOT_W = 7;

endpackage

// File: rtl/ram_word_decode.sv
// Combinational decode of one result-RAM word into F1 and the 3-bit adder result.
module ram_word_decode
    import ram_scan_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic              f1_bit,
    output logic [ADD_W-1:0]  add_val
);

    assign f1_bit  = word[F1_POS];
    assign add_val = {word[COUT_POS], word[SUM_MSB:SUM_LSB]};

endmodule

// File: rtl/ram_scan_reader.sv
// Sweeps the result RAM, presents each decoded word over VALID/READY and
// accumulates F1 count, adder total and first-occurrence maximum.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int AW         = 4,
    parameter int DW         = 4,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    output logic [AW-1:0]    A,
    input  logic [DW-1:0]    Do,
    output logic             BUSY,
    output logic             VALID,
    input  logic             READY,
    output logic [AW-1:0]    ADDR_OUT,
    output logic [DW-1:0]    DOUT,
    output logic             F1_BIT,
    output logic [ADD_W-1:0] ADD_VAL,
    output logic [CNT_W-1:0] F1_CNT,
    output logic [TOT_W-1:0] TOTAL,
    output logic [ADD_W-1:0] MAX_VAL,
    output logic [AW-1:0]    MAX_ADDR,
    output logic             DONE
);

    if (LAST_ADDR < FIRST_ADDR) begin : g_bad_range
        $error("ram_scan_reader: LAST_ADDR must be >= FIRST_ADDR");
    end
    if (DW != WORD_W) begin : g_bad_width
        $error("ram_scan_reader: DW must match the 4-bit word layout");
    end

    localparam logic [AW-1:0] FIRST_A = AW'(FIRST_ADDR);
    localparam logic [AW-1:0] LAST_A  = AW'(LAST_ADDR);

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic             dec_f1;
    logic [ADD_W-1:0] dec_add;
    logic             at_last;

    ram_word_decode u_decode (
        .word   (Do),
        .f1_bit (dec_f1),
        .add_val(dec_add)
    );

    assign at_last = (A == LAST_A);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ABORT only matters while a scan is running; START only when it is not.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (START) state_d = ST_SETTLE;
            ST_SETTLE:        state_d = ABORT ? ST_IDLE : ST_CAPTURE;
            ST_CAPTURE:       state_d = ABORT ? ST_IDLE : ST_HOLD;
            ST_HOLD: begin
                if (ABORT)      state_d = ST_IDLE;
                else if (READY) state_d = at_last ? ST_DONE : ST_SETTLE;
            end
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY  = 1'b0;
        VALID = 1'b0;
        DONE  = 1'b0;
        case (state_q)
            ST_SETTLE, ST_CAPTURE: BUSY = 1'b1;
            ST_HOLD: begin
                BUSY  = 1'b1;
                VALID = 1'b1;
            end
            ST_DONE: DONE = 1'b1;
            default: ;
        endcase
    end

    // Statistics change only in CAPTURE, so HOLD stalls can never recount an entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            A        <= '0;
            ADDR_OUT <= '0;
            DOUT     <= '0;
            F1_BIT   <= 1'b0;
            ADD_VAL  <= '0;
            F1_CNT   <= '0;
            TOTAL    <= '0;
            MAX_VAL  <= '0;
            MAX_ADDR <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        A        <= FIRST_A;
                        F1_CNT   <= '0;
                        TOTAL    <= '0;
                        MAX_VAL  <= '0;
                        MAX_ADDR <= '0;
                    end
                end
                ST_CAPTURE: begin
                    DOUT     <= Do;
                    F1_BIT   <= dec_f1;
                    ADD_VAL  <= dec_add;
                    ADDR_OUT <= A;
                    F1_CNT   <= F1_CNT + CNT_W'(dec_f1);
                    TOTAL    <= TOTAL + TOT_W'(dec_add);
                    if (dec_add > MAX_VAL) begin
                        MAX_VAL  <= dec_add;
                        MAX_ADDR <= A;
                    end
                end
                ST_HOLD: begin
                    if (!ABORT && READY && !at_last) A <= A + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader with a RAM array, an arithmetic statistics model and per-cycle output checks.
module tb_ram_scan_reader;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       ABORT;
    logic [3:0] A;
    logic [3:0] ram_do;
    logic       BUSY;
    logic       VALID;
    logic       READY;
    logic [3:0] ADDR_OUT;
    logic [3:0] DOUT;
    logic       F1_BIT;
    logic [2:0] ADD_VAL;
    logic [4:0] F1_CNT;
    logic [6:0] TOTAL;
    logic [2:0] MAX_VAL;
    logic [3:0] MAX_ADDR;
    logic       DONE;

    logic [3:0] mem [16];
    int checks;
    int failures;
    int exp_addr;
    int hs_count;

    assign ram_do = mem[A];

    ram_scan_reader #(
        .AW(4),
        .DW(4),
        .FIRST_ADDR(0),
        .LAST_ADDR(15)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .A(A), .Do(ram_do), .BUSY(BUSY), .VALID(VALID), .READY(READY),
        .ADDR_OUT(ADDR_OUT), .DOUT(DOUT), .F1_BIT(F1_BIT), .ADD_VAL(ADD_VAL),
        .F1_CNT(F1_CNT), .TOTAL(TOTAL), .MAX_VAL(MAX_VAL), .MAX_ADDR(MAX_ADDR),
        .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Statistics over addresses 0..last: F1 is the word's low bit, the adder value is word/2.
    function automatic void model_stats(input int last, output int f1, output int tot,
                                        output int mx, output int mxa);
        f1 = 0; tot = 0; mx = 0; mxa = 0;
        for (int i = 0; i <= last; i++) begin
            int w;
            w = int'(mem[i]);
            f1 += w % 2;
            tot += w / 2;
            if (w / 2 > mx) begin
                mx = w / 2;
                mxa = i;
            end
        end
    endfunction

    task automatic monitor();
        int f1, tot, mx, mxa, w;
        if (!BUSY) exp_addr = 0;
        if (VALID) begin
            w = int'(mem[exp_addr % 16]);
            model_stats(exp_addr % 16, f1, tot, mx, mxa);
            check("busy_with_valid", int'(BUSY), 1);
            check("addr_out", int'(ADDR_OUT), exp_addr);
            check("a_bus", int'(A), exp_addr);
            check("dout", int'(DOUT), w);
            check("f1_bit", int'(F1_BIT), w % 2);
            check("add_val", int'(ADD_VAL), w / 2);
            check("f1_cnt_run", int'(F1_CNT), f1);
            check("total_run", int'(TOTAL), tot);
            check("max_val_run", int'(MAX_VAL), mx);
            check("max_addr_run", int'(MAX_ADDR), mxa);
        end
    endtask

    // One clock: note whether a handshake happens at the coming edge, then check at the falling edge.
    task automatic step();
        bit hs;
        hs = VALID && READY;
        @(negedge CLK);
        if (hs) begin
            hs_count++;
            exp_addr++;
        end
        monitor();
    endtask

    task automatic check_all_zero();
        check("rst_a", int'(A), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_valid", int'(VALID), 0);
        check("rst_addr_out", int'(ADDR_OUT), 0);
        check("rst_dout", int'(DOUT), 0);
        check("rst_f1_bit", int'(F1_BIT), 0);
        check("rst_add_val", int'(ADD_VAL), 0);
        check("rst_f1_cnt", int'(F1_CNT), 0);
        check("rst_total", int'(TOTAL), 0);
        check("rst_max_val", int'(MAX_VAL), 0);
        check("rst_max_addr", int'(MAX_ADDR), 0);
        check("rst_done", int'(DONE), 0);
    endtask

    task automatic do_scan(input int stall_addr, input int stall_len, input int pulse_addr,
                           input bit with_abort, output int cycles, output int hs);
        int stalled = 0;
        int hs0 = hs_count;
        bit pulsed = 0;
        START = 1'b1; ABORT = with_abort; READY = 1'b1;
        step();
        START = 1'b0; ABORT = 1'b0;
        cycles = 0;
        while (!DONE && cycles < 300) begin
            if (VALID && int'(ADDR_OUT) == stall_addr && stalled < stall_len) begin
                READY = 1'b0;
                stalled++;
            end else begin
                READY = 1'b1;
            end
            START = 1'b0;
            if (BUSY && int'(A) == pulse_addr && !pulsed) begin
                START = 1'b1;
                pulsed = 1'b1;
            end
            step();
            cycles++;
        end
        START = 1'b0;
        check("scan_done", int'(DONE), 1);
        hs = hs_count - hs0;
    endtask

    task automatic check_final(input int lf1, input int ltot, input int lmx, input int lmxa);
        int f1, tot, mx, mxa;
        model_stats(15, f1, tot, mx, mxa);
        check("model_f1_pin", f1, lf1);
        check("model_total_pin", tot, ltot);
        check("model_max_pin", mx, lmx);
        check("model_maxaddr_pin", mxa, lmxa);
        check("final_f1_cnt", int'(F1_CNT), lf1);
        check("final_total", int'(TOTAL), ltot);
        check("final_max_val", int'(MAX_VAL), lmx);
        check("final_max_addr", int'(MAX_ADDR), lmxa);
        check("final_busy", int'(BUSY), 0);
        check("final_valid", int'(VALID), 0);
        check("final_a_hold", int'(A), 15);
    endtask

    task automatic do_abort(input int sight, input int lf1, input int ltot);
        int n = 0;
        int seen = 0;
        int f1, tot, mx, mxa;
        START = 1'b1; READY = 1'b1;
        step();
        START = 1'b0;
        while (n < 200) begin
            if (BUSY && !VALID && int'(A) == 4) begin
                seen++;
                if (seen == sight) break;
            end
            step();
            n++;
        end
        check("abort_reach", seen, sight);
        ABORT = 1'b1; START = 1'b1;
        step();
        ABORT = 1'b0; START = 1'b0;
        model_stats(sight == 1 ? 3 : 4, f1, tot, mx, mxa);
        check("abort_model_f1_pin", f1, lf1);
        check("abort_model_tot_pin", tot, ltot);
        check("abort_busy", int'(BUSY), 0);
        check("abort_valid", int'(VALID), 0);
        check("abort_done", int'(DONE), 0);
        check("abort_f1_cnt", int'(F1_CNT), lf1);
        check("abort_total", int'(TOTAL), ltot);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        step();
        check("idle_abort_busy", int'(BUSY), 0);
        check("idle_abort_valid", int'(VALID), 0);
        check("idle_abort_f1_cnt", int'(F1_CNT), lf1);
        check("idle_abort_total", int'(TOTAL), ltot);
    endtask

    initial begin
        int cycles, hs, n;
        checks = 0; failures = 0; exp_addr = 0; hs_count = 0;
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; READY = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        step();
        step();
        check_all_zero();
        RST = 1'b0;
        step();

        // 1: all zeros
        do_scan(-1, 0, -1, 1'b0, cycles, hs);
        check("t1_handshakes", hs, 16);
        check("t1_cycles", cycles, 48);
        check_final(0, 0, 0, 0);

        // 2: single entry at address 5
        mem[5] = 4'b1011;
        do_scan(-1, 0, -1, 1'b0, cycles, hs);
        check("t2_handshakes", hs, 16);
        check_final(1, 5, 5, 5);

        // 3: tie between addresses 3 and 9
        for (int i = 0; i < 16; i++) mem[i] = 4'b0001;
        mem[3] = 4'b1110;
        mem[9] = 4'b1110;
        do_scan(-1, 0, -1, 1'b0, cycles, hs);
        check("t3_handshakes", hs, 16);
        check_final(14, 14, 7, 3);

        // 4: backpressure on address 2
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        do_scan(2, 3, -1, 1'b0, cycles, hs);
        check("t4_handshakes", hs, 16);
        check("t4_cycles", cycles, 51);
        check_final(8, 56, 7, 14);

        // 5: asynchronous reset while holding address 7
        START = 1'b1; READY = 1'b1;
        step();
        START = 1'b0;
        n = 0;
        while (!(VALID && int'(ADDR_OUT) == 7) && n < 200) begin
            step();
            n++;
        end
        READY = 1'b0;
        check("t5_reach_hold7", int'(VALID && ADDR_OUT == 4'd7), 1);
        #2 RST = 1'b1;
        #1 check_all_zero();
        step();
        RST = 1'b0;
        step();
        do_scan(-1, 0, -1, 1'b0, cycles, hs);
        check("t5_handshakes", hs, 16);
        check("t5_cycles", cycles, 48);
        check_final(8, 56, 7, 14);

        // 6: START mid-scan ignored; ABORT+START at address 4 in SETTLE, then in CAPTURE
        do_scan(-1, 0, 1, 1'b0, cycles, hs);
        check("t6_handshakes", hs, 16);
        check("t6_cycles", cycles, 48);
        do_abort(1, 2, 2);
        do_abort(2, 2, 4);
        do_scan(-1, 0, -1, 1'b1, cycles, hs);
        check("t6_restart_handshakes", hs, 16);
        check_final(8, 56, 7, 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
